// File: rtl/apb_ucpd_rx_decode.sv
// UCPD receive symbol decoder: preamble detection, 5-bit symbol alignment,
// ordered-set (SOP/SOP'/SOP''/HRST/CRST) scoring and 4b5b-to-byte decoding until EOP.
module apb_ucpd_rx_decode #(
   parameter int PRE_MIN_BITS = 16,
   parameter int MAX_BYTES    = 264
) (
   input  logic       ic_clk,
   input  logic       ic_rst_n,
   input  logic       ucpden,
   input  logic       rx_bit,
   input  logic       rx_bit_vld,
   input  logic       rx_pre_en,
   input  logic       rx_sop_en,
   input  logic       rx_data_en,
   input  logic [4:0] rx_ordset_en,
   output logic       rx_pre_cmplt,
   output logic       rx_sop_cmplt,
   output logic       rx_ordset_vld,
   output logic [2:0] rx_ordset_type,
   output logic       hrst_vld,
   output logic       crst_vld,
   output logic [7:0] rx_byte,
   output logic       rx_byte_vld,
   output logic [9:0] rx_bytecnt,
   output logic       eop_ok,
   output logic       rx_sym_err,
   output logic       rx_ovr
);
   localparam int PCW = $clog2(PRE_MIN_BITS + 1);
   localparam logic [PCW-1:0] PRE_MAX = PCW'(PRE_MIN_BITS);
   localparam logic [4:0] K_SYNC1 = 5'b00011, K_SYNC2 = 5'b10001, K_SYNC3 = 5'b01100;
   localparam logic [4:0] K_RST1 = 5'b11100, K_RST2 = 5'b10011, K_EOP = 5'b10110;

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_ORD, S_DATA, S_HALT} state_t;

   // Reference ordered sets packed {sym3, sym2, sym1, sym0}; sym0 is received first.
   function automatic logic [19:0] ord_pat(input int t);
      case (t)
         0:       ord_pat = {K_SYNC2, K_SYNC1, K_SYNC1, K_SYNC1};
         1:       ord_pat = {K_SYNC3, K_SYNC3, K_SYNC1, K_SYNC1};
         2:       ord_pat = {K_SYNC3, K_SYNC1, K_SYNC3, K_SYNC1};
         3:       ord_pat = {K_RST2, K_RST1, K_RST1, K_RST1};
         default: ord_pat = {K_SYNC3, K_RST1, K_SYNC1, K_RST1};
      endcase
   endfunction

   // Returns {valid, nibble} for a 4b5b data code.
   function automatic logic [4:0] dec5(input logic [4:0] c);
      case (c)
         5'b01111: dec5 = 5'h10;  5'b10010: dec5 = 5'h11;
         5'b00101: dec5 = 5'h12;  5'b10101: dec5 = 5'h13;
         5'b01010: dec5 = 5'h14;  5'b11010: dec5 = 5'h15;
         5'b01110: dec5 = 5'h16;  5'b11110: dec5 = 5'h17;
         5'b01001: dec5 = 5'h18;  5'b11001: dec5 = 5'h19;
         5'b01101: dec5 = 5'h1A;  5'b11101: dec5 = 5'h1B;
         5'b01011: dec5 = 5'h1C;  5'b11011: dec5 = 5'h1D;
         5'b00111: dec5 = 5'h1E;  5'b10111: dec5 = 5'h1F;
         default:  dec5 = 5'h00;
      endcase
   endfunction

   state_t           state_reg, state_next;
   logic [4:0]       sr_reg, sr_next, sr_shift;
   logic [PCW-1:0]   pre_cnt_reg, pre_cnt_next;
   logic             pre_ok_reg, pre_ok_next;
   logic [2:0][4:0]  ord_reg, ord_next;
   logic [1:0]       sym_cnt_reg, sym_cnt_next;
   logic [2:0]       bit_cnt_reg, bit_cnt_next;
   logic [3:0]       low_nib_reg, low_nib_next;
   logic [7:0]       byte_reg, byte_next;
   logic [9:0]       bytecnt_reg, bytecnt_next;
   logic             ordset_vld_reg, ordset_vld_next;
   logic [2:0]       ordset_type_reg, ordset_type_next;
   logic             pre_cmplt_reg, pre_cmplt_next, sop_cmplt_reg, sop_cmplt_next;
   logic             hrst_reg, hrst_next, crst_reg, crst_next;
   logic             byte_vld_reg, byte_vld_next, eop_ok_reg, eop_ok_next;
   logic             sym_err_reg, sym_err_next, ovr_reg, ovr_next;

   logic             any_en, bit_evt;
   logic [19:0]      ord_cur;
   logic [4:0]       ord_match;
   logic [2:0]       match_type;
   logic [4:0]       dec;

   assign any_en   = rx_pre_en | rx_sop_en | rx_data_en;
   assign bit_evt  = rx_bit_vld & any_en;
   assign sr_shift = {rx_bit, sr_reg[4:1]};
   assign ord_cur  = {sr_shift, ord_reg[2], ord_reg[1], ord_reg[0]};
   assign dec      = dec5(sr_shift);

   // Tolerant scoring: an ordered set matches with any 3 of its 4 symbols correct.
   for (genvar gi = 0; gi < 5; gi++) begin : g_score
      localparam logic [19:0] PAT = ord_pat(gi);
      logic [2:0] hits;
      assign hits = 3'(ord_cur[4:0] == PAT[4:0]) + 3'(ord_cur[9:5] == PAT[9:5])
                  + 3'(ord_cur[14:10] == PAT[14:10]) + 3'(ord_cur[19:15] == PAT[19:15]);
      assign ord_match[gi] = rx_ordset_en[gi] && (hits >= 3'd3);
   end

   always_comb begin
      match_type = 3'd2;
      if (ord_match[3])      match_type = 3'd3;
      else if (ord_match[4]) match_type = 3'd4;
      else if (ord_match[0]) match_type = 3'd0;
      else if (ord_match[1]) match_type = 3'd1;
   end

   always_comb begin
      state_next       = state_reg;
      sr_next          = sr_reg;
      pre_cnt_next     = pre_cnt_reg;
      pre_ok_next      = pre_ok_reg;
      ord_next         = ord_reg;
      sym_cnt_next     = sym_cnt_reg;
      bit_cnt_next     = bit_cnt_reg;
      low_nib_next     = low_nib_reg;
      byte_next        = byte_reg;
      bytecnt_next     = bytecnt_reg;
      ordset_vld_next  = ordset_vld_reg;
      ordset_type_next = ordset_type_reg;
      pre_cmplt_next   = 1'b0;
      sop_cmplt_next   = 1'b0;
      hrst_next        = 1'b0;
      crst_next        = 1'b0;
      byte_vld_next    = 1'b0;
      eop_ok_next      = 1'b0;
      sym_err_next     = 1'b0;
      ovr_next         = 1'b0;
      if (!any_en && state_reg != S_IDLE) begin
         state_next = S_IDLE;
      end else begin
         case (state_reg)
            S_IDLE: if (rx_pre_en) begin
               state_next      = S_PRE;
               sr_next         = '0;
               pre_cnt_next    = '0;
               pre_ok_next     = 1'b0;
               ordset_vld_next = 1'b0;
               bytecnt_next    = '0;
            end
            S_PRE: if (bit_evt) begin
               sr_next = sr_shift;
               if (rx_bit != sr_reg[4])
                  pre_cnt_next = (pre_cnt_reg == PRE_MAX) ? pre_cnt_reg : pre_cnt_reg + 1'b1;
               else
                  pre_cnt_next = '0;
               // The first K-code breaks the alternation, so a qualified preamble is latched.
               pre_ok_next = pre_ok_reg | (pre_cnt_reg == PRE_MAX);
               if ((pre_ok_reg || pre_cnt_reg == PRE_MAX) && (sr_shift == K_SYNC1 || sr_shift == K_RST1)) begin
                  ord_next[0]    = sr_shift;
                  sym_cnt_next   = 2'd1;
                  bit_cnt_next   = '0;
                  pre_cmplt_next = 1'b1;
                  state_next     = S_ORD;
               end
            end
            S_ORD: if (bit_evt) begin
               sr_next = sr_shift;
               if (bit_cnt_reg == 3'd4) begin
                  bit_cnt_next = '0;
                  if (sym_cnt_reg == 2'd3) begin
                     sop_cmplt_next = 1'b1;
                     sym_cnt_next   = '0;
                     state_next     = S_HALT;
                     if (|ord_match) begin
                        ordset_vld_next  = 1'b1;
                        ordset_type_next = match_type;
                        hrst_next        = (match_type == 3'd3);
                        crst_next        = (match_type == 3'd4);
                        if (match_type <= 3'd2) state_next = S_DATA;
                     end else begin
                        ordset_vld_next = 1'b0;
                     end
                  end else begin
                     ord_next[sym_cnt_reg] = sr_shift;
                     sym_cnt_next          = sym_cnt_reg + 2'd1;
                  end
               end else begin
                  bit_cnt_next = bit_cnt_reg + 3'd1;
               end
            end
            S_DATA: if (bit_evt) begin
               sr_next = sr_shift;
               if (bit_cnt_reg == 3'd4) begin
                  bit_cnt_next = '0;
                  if (dec[4]) begin
                     if (!sym_cnt_reg[0]) begin
                        low_nib_next = dec[3:0];
                        sym_cnt_next = 2'd1;
                     end else begin
                        sym_cnt_next = 2'd0;
                        if (bytecnt_reg == 10'(MAX_BYTES)) begin
                           ovr_next   = 1'b1;
                           state_next = S_HALT;
                        end else begin
                           byte_next     = {dec[3:0], low_nib_reg};
                           byte_vld_next = 1'b1;
                           bytecnt_next  = bytecnt_reg + 10'd1;
                        end
                     end
                  end else begin
                     eop_ok_next  = (sr_shift == K_EOP) && !sym_cnt_reg[0];
                     sym_err_next = !((sr_shift == K_EOP) && !sym_cnt_reg[0]);
                     state_next   = S_HALT;
                  end
               end else begin
                  bit_cnt_next = bit_cnt_reg + 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge ic_clk or negedge ic_rst_n) begin
      if (!ic_rst_n || !ucpden) begin
         state_reg       <= S_IDLE;
         sr_reg          <= '0;
         pre_cnt_reg     <= '0;
         pre_ok_reg      <= 1'b0;
         ord_reg         <= '0;
         sym_cnt_reg     <= '0;
         bit_cnt_reg     <= '0;
         low_nib_reg     <= '0;
         byte_reg        <= '0;
         bytecnt_reg     <= '0;
         ordset_vld_reg  <= 1'b0;
         ordset_type_reg <= '0;
         pre_cmplt_reg   <= 1'b0;
         sop_cmplt_reg   <= 1'b0;
         hrst_reg        <= 1'b0;
         crst_reg        <= 1'b0;
         byte_vld_reg    <= 1'b0;
         eop_ok_reg      <= 1'b0;
         sym_err_reg     <= 1'b0;
         ovr_reg         <= 1'b0;
      end else begin
         state_reg       <= state_next;
         sr_reg          <= sr_next;
         pre_cnt_reg     <= pre_cnt_next;
         pre_ok_reg      <= pre_ok_next;
         ord_reg         <= ord_next;
         sym_cnt_reg     <= sym_cnt_next;
         bit_cnt_reg     <= bit_cnt_next;
         low_nib_reg     <= low_nib_next;
         byte_reg        <= byte_next;
         bytecnt_reg     <= bytecnt_next;
         ordset_vld_reg  <= ordset_vld_next;
         ordset_type_reg <= ordset_type_next;
         pre_cmplt_reg   <= pre_cmplt_next;
         sop_cmplt_reg   <= sop_cmplt_next;
         hrst_reg        <= hrst_next;
         crst_reg        <= crst_next;
         byte_vld_reg    <= byte_vld_next;
         eop_ok_reg      <= eop_ok_next;
         sym_err_reg     <= sym_err_next;
         ovr_reg         <= ovr_next;
      end
   end

   assign rx_pre_cmplt   = pre_cmplt_reg;
   assign rx_sop_cmplt   = sop_cmplt_reg;
   assign rx_ordset_vld  = ordset_vld_reg;
   assign rx_ordset_type = ordset_type_reg;
   assign hrst_vld       = hrst_reg;
   assign crst_vld       = crst_reg;
   assign rx_byte        = byte_reg;
   assign rx_byte_vld    = byte_vld_reg;
   assign rx_bytecnt     = bytecnt_reg;
   assign eop_ok         = eop_ok_reg;
   assign rx_sym_err     = sym_err_reg;
   assign rx_ovr         = ovr_reg;
endmodule

// File: tb/tb_apb_ucpd_rx_decode.sv
// Scoreboard bench for apb_ucpd_rx_decode: expected status events are queued as
// stimulus is driven and compared when the decoder pulses an output.
module tb_apb_ucpd_rx_decode;
   localparam int MAXB = 4;
   localparam logic [4:0] S1 = 5'b00011, S2 = 5'b10001, S3 = 5'b01100;
   localparam logic [4:0] R1 = 5'b11100, R2 = 5'b10011, EOP = 5'b10110;
   localparam logic [4:0] ENC [16] = '{5'b01111, 5'b10010, 5'b00101, 5'b10101,
                                       5'b01010, 5'b11010, 5'b01110, 5'b11110,
                                       5'b01001, 5'b11001, 5'b01101, 5'b11101,
                                       5'b01011, 5'b11011, 5'b00111, 5'b10111};
   localparam logic [7:0] K_PRE = 8'h01, K_SOP = 8'h02, K_BYTE = 8'h04, K_EOP = 8'h08;
   localparam logic [7:0] K_ERR = 8'h10, K_OVR = 8'h20, K_HRST = 8'h40, K_CRST = 8'h80;

   logic       ic_clk = 1'b0, ic_rst_n = 1'b0, ucpden = 1'b0;
   logic       rx_bit = 1'b0, rx_bit_vld = 1'b0;
   logic       rx_pre_en = 1'b0, rx_sop_en = 1'b0, rx_data_en = 1'b0;
   logic [4:0] rx_ordset_en = 5'b11111;
   logic       rx_pre_cmplt, rx_sop_cmplt, rx_ordset_vld, hrst_vld, crst_vld;
   logic [2:0] rx_ordset_type;
   logic [7:0] rx_byte;
   logic       rx_byte_vld, eop_ok, rx_sym_err, rx_ovr;
   logic [9:0] rx_bytecnt;

   int          n_cmp = 0, n_err = 0;
   logic [31:0] exp_q[$];
   int          exp_cnt;
   bit          exp_halt;

   apb_ucpd_rx_decode #(.PRE_MIN_BITS(16), .MAX_BYTES(MAXB)) dut (
      .ic_clk(ic_clk), .ic_rst_n(ic_rst_n), .ucpden(ucpden),
      .rx_bit(rx_bit), .rx_bit_vld(rx_bit_vld),
      .rx_pre_en(rx_pre_en), .rx_sop_en(rx_sop_en), .rx_data_en(rx_data_en),
      .rx_ordset_en(rx_ordset_en),
      .rx_pre_cmplt(rx_pre_cmplt), .rx_sop_cmplt(rx_sop_cmplt),
      .rx_ordset_vld(rx_ordset_vld), .rx_ordset_type(rx_ordset_type),
      .hrst_vld(hrst_vld), .crst_vld(crst_vld),
      .rx_byte(rx_byte), .rx_byte_vld(rx_byte_vld), .rx_bytecnt(rx_bytecnt),
      .eop_ok(eop_ok), .rx_sym_err(rx_sym_err), .rx_ovr(rx_ovr)
   );

   always #5 ic_clk = ~ic_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ev(input logic [7:0] kind, input logic [23:0] data);
      return {kind, data};
   endfunction

   // Event data: SOP {vld, type, hrst, crst}; BYTE {bytecnt, byte}; OVR bytecnt.
   always @(negedge ic_clk) begin
      logic [7:0]  kind;
      logic [23:0] data;
      kind = {crst_vld, hrst_vld, rx_ovr, rx_sym_err, eop_ok, rx_byte_vld, rx_sop_cmplt, rx_pre_cmplt};
      if (kind != 8'd0) begin
         data = '0;
         if (rx_sop_cmplt)
            data = {18'd0, rx_ordset_vld, (rx_ordset_vld ? rx_ordset_type : 3'd0), hrst_vld, crst_vld};
         else if (rx_byte_vld)
            data = {6'd0, rx_bytecnt, rx_byte};
         else if (rx_ovr)
            data = {14'd0, rx_bytecnt};
         $display("t=%0t event kind=%02h data=%06h", $time, kind, data);
         if (exp_q.size() == 0) chk("unexpected_event", ev(kind, data), 32'd0);
         else chk("event", ev(kind, data), exp_q.pop_front());
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge ic_clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      rx_bit = b;
      rx_bit_vld = 1'b1;
      idle(1);
      rx_bit_vld = 1'b0;
      idle(1);
   endtask

   task automatic send_sym(input logic [4:0] code);
      for (int i = 0; i < 5; i++) send_bit(code[i]);
   endtask

   task automatic send_pre(input int n);
      for (int i = 0; i < n; i++) send_bit(i[0]);
   endtask

   task automatic push_sop(input logic v, input logic [2:0] t, input logic h, input logic c);
      exp_q.push_back(ev(K_SOP | (h ? K_HRST : 8'h0) | (c ? K_CRST : 8'h0), {18'd0, v, t, h, c}));
   endtask

   // Byte model: counts bytes, overflows past MAXB and then halts the packet.
   task automatic send_byte(input logic [7:0] b);
      if (!exp_halt) begin
         if (exp_cnt == MAXB) begin
            exp_q.push_back(ev(K_OVR, 24'(exp_cnt)));
            exp_halt = 1'b1;
         end else begin
            exp_cnt++;
            exp_q.push_back(ev(K_BYTE, {6'd0, 10'(exp_cnt), b}));
         end
      end
      send_sym(ENC[b[3:0]]);
      send_sym(ENC[b[7:4]]);
   endtask

   task automatic send_eop();
      if (!exp_halt) exp_q.push_back(ev(K_EOP, 24'd0));
      exp_halt = 1'b1;
      send_sym(EOP);
   endtask

   task automatic start_pkt(input logic [4:0] mask);
      rx_ordset_en = mask;
      exp_cnt = 0;
      exp_halt = 1'b0;
      rx_pre_en = 1'b1;
      idle(2);
   endtask

   task automatic end_pkt(input string tag);
      idle(4);
      chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      rx_pre_en = 1'b0;
      idle(3);
   endtask

   task automatic sop_hdr(input logic [4:0] a, b, c, d);
      send_pre(20);
      send_sym(a); send_sym(b); send_sym(c); send_sym(d);
   endtask

   initial begin
      idle(3);
      chk("rst_bytecnt", 32'(rx_bytecnt), 32'd0);
      chk("rst_pulses", 32'({rx_pre_cmplt, rx_sop_cmplt, rx_byte_vld, eop_ok, rx_sym_err, rx_ovr}), 32'd0);
      chk("rst_ordset", 32'({rx_ordset_vld, rx_ordset_type}), 32'd0);
      ic_rst_n = 1'b1;
      ucpden = 1'b1;
      idle(2);

      // Nominal SOP packet with two bytes and EOP.
      start_pkt(5'b11111);
      exp_q.push_back(ev(K_PRE, 24'd0));
      push_sop(1'b1, 3'd0, 1'b0, 1'b0);
      sop_hdr(S1, S1, S1, S2);
      send_byte(8'hA5);
      send_byte(8'h3C);
      send_eop();
      idle(2);
      chk("sop_bytecnt", 32'(rx_bytecnt), 32'd2);
      chk("sop_byte_hold", 32'(rx_byte), 32'h3C);
      chk("sop_type", 32'({rx_ordset_vld, rx_ordset_type}), 32'h8);
      end_pkt("sop");

      // Hard reset with one corrupted symbol; later data is ignored.
      start_pkt(5'b11111);
      exp_q.push_back(ev(K_PRE, 24'd0));
      push_sop(1'b1, 3'd3, 1'b1, 1'b0);
      sop_hdr(R1, R1, S1, R2);
      send_byte(8'h00);
      exp_q.delete();
      idle(2);
      chk("hrst_type", 32'({rx_ordset_vld, rx_ordset_type}), 32'hB);
      chk("hrst_no_bytes", 32'(rx_bytecnt), 32'd0);
      end_pkt("hrst");

      // Cable reset with CRST masked off: no match.
      start_pkt(5'b01111);
      exp_q.push_back(ev(K_PRE, 24'd0));
      push_sop(1'b0, 3'd0, 1'b0, 1'b0);
      sop_hdr(R1, S1, R1, S3);
      send_sym(ENC[1]); send_sym(ENC[2]);
      idle(2);
      chk("crst_masked_vld", 32'(rx_ordset_vld), 32'd0);
      end_pkt("crst_masked");

      // Cable reset enabled.
      start_pkt(5'b11111);
      exp_q.push_back(ev(K_PRE, 24'd0));
      push_sop(1'b1, 3'd4, 1'b0, 1'b1);
      sop_hdr(R1, S1, R1, S3);
      end_pkt("crst");

      // Invalid data code.
      start_pkt(5'b11111);
      exp_q.push_back(ev(K_PRE, 24'd0));
      push_sop(1'b1, 3'd0, 1'b0, 1'b0);
      exp_q.push_back(ev(K_ERR, 24'd0));
      sop_hdr(S1, S1, S1, S2);
      send_sym(5'b00000);
      end_pkt("bad_code");

      // EOP on an odd symbol boundary.
      start_pkt(5'b11111);
      exp_q.push_back(ev(K_PRE, 24'd0));
      push_sop(1'b1, 3'd0, 1'b0, 1'b0);
      exp_q.push_back(ev(K_ERR, 24'd0));
      sop_hdr(S1, S1, S1, S2);
      send_sym(ENC[5]);
      send_sym(EOP);
      end_pkt("odd_eop");

      // SOP'' packet.
      start_pkt(5'b11111);
      exp_q.push_back(ev(K_PRE, 24'd0));
      push_sop(1'b1, 3'd2, 1'b0, 1'b0);
      sop_hdr(S1, S3, S1, S3);
      send_byte(8'h7E);
      send_eop();
      end_pkt("sopdp");

      // Short preamble: nothing may be reported.
      start_pkt(5'b11111);
      send_pre(10);
      send_sym(S1); send_sym(S1); send_sym(S1); send_sym(S2);
      end_pkt("short_pre");

      // Abort mid-byte by dropping the FSM enables.
      start_pkt(5'b11111);
      exp_q.push_back(ev(K_PRE, 24'd0));
      push_sop(1'b1, 3'd0, 1'b0, 1'b0);
      sop_hdr(S1, S1, S1, S2);
      send_byte(8'h11);
      send_sym(ENC[2]);
      rx_pre_en = 1'b0;
      idle(2);
      send_sym(ENC[3]);
      send_sym(EOP);
      rx_pre_en = 1'b1;
      idle(2);
      chk("abort_bytecnt_clr", 32'(rx_bytecnt), 32'd0);
      end_pkt("abort");

      // Overflow: MAXB bytes accepted, the next one raises rx_ovr.
      start_pkt(5'b11111);
      exp_q.push_back(ev(K_PRE, 24'd0));
      push_sop(1'b1, 3'd0, 1'b0, 1'b0);
      sop_hdr(S1, S1, S1, S2);
      for (int i = 0; i < 5; i++) send_byte(8'(8'h21 * (i + 1)));
      send_eop();
      idle(2);
      chk("ovr_bytecnt", 32'(rx_bytecnt), 32'(MAXB));
      chk("ovr_last_byte", 32'(rx_byte), 32'h84);
      ucpden = 1'b0;
      idle(1);
      chk("ucpden_clr", 32'({rx_bytecnt, rx_byte, rx_ordset_vld}), 32'd0);
      ucpden = 1'b1;
      end_pkt("ovr");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
